// File: rtl/irq_request_register.sv
// Interrupt request capture stage: synchronises raw IR lines, latches edge- or
// level-triggered requests, applies the mask and clears acknowledged bits.
module irq_request_register #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] IR,
  input  logic             LTIM,
  input  logic [WIDTH-1:0] IMR,
  input  logic             CLR_EN,
  input  logic [WIDTH-1:0] CLR_SEL,
  output logic [WIDTH-1:0] IRR,
  output logic             ANY_REQ
);

  typedef enum logic [1:0] {
    ST_ARMED   = 2'd0,
    ST_PENDING = 2'd1,
    ST_SPENT   = 2'd2
  } edge_state_e;

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
  logic [WIDTH-1:0] ir_dly_q, ir_dly_d;
  logic [WIDTH-1:0] irr_q, irr_d;
  logic             ltim_q, ltim_d;

  logic [WIDTH-1:0] ir_s;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] clr;
  logic [WIDTH-1:0] pending;
  logic             ltim_chg;

  assign ir_s     = sync_q[SYNC_STAGES-1];
  assign rise     = ir_s & ~ir_dly_q;
  assign clr      = CLR_SEL & {WIDTH{CLR_EN}};
  assign ltim_chg = LTIM ^ ltim_q;

  always_comb begin
    sync_d   = {sync_q[SYNC_STAGES-2:0], IR};
    ir_dly_d = ir_s;
    ltim_d   = LTIM;
    irr_d    = pending & ~IMR;
  end

  // ltim_q loads the live mode during reset so release never looks like a mode change
  always_ff @(posedge CLK) begin
    if (RESET) begin
      sync_q   <= '0;
      ir_dly_q <= '0;
      irr_q    <= '0;
      ltim_q   <= LTIM;
    end else begin
      sync_q   <= sync_d;
      ir_dly_q <= ir_dly_d;
      irr_q    <= irr_d;
      ltim_q   <= ltim_d;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    edge_state_e st_q, st_d;
    logic        pend_q, pend_d;

    // Per-line request state; clear beats a same-cycle set
    always_comb begin
      st_d   = st_q;
      pend_d = pend_q;
      if (ltim_chg) begin
        pend_d = 1'b0;
        st_d   = ir_s[i] ? ST_SPENT : ST_ARMED;
      end else if (LTIM) begin
        pend_d = ir_s[i] & ~clr[i];
      end else begin
        case (st_q)
          ST_ARMED:   if (rise[i]) st_d = clr[i] ? ST_SPENT : ST_PENDING;
          ST_PENDING: if (clr[i])  st_d = ir_s[i] ? ST_SPENT : ST_ARMED;
          ST_SPENT:   if (!ir_s[i]) st_d = ST_ARMED;
          default:    st_d = ST_ARMED;
        endcase
        pend_d = (st_d == ST_PENDING);
      end
    end

    always_ff @(posedge CLK) begin
      if (RESET) begin
        st_q   <= ST_ARMED;
        pend_q <= 1'b0;
      end else begin
        st_q   <= st_d;
        pend_q <= pend_d;
      end
    end

    assign pending[i] = pend_q;
  end

  assign IRR     = irr_q;
  assign ANY_REQ = |irr_q;

endmodule
